// File: rtl/class2_vote_pkg.sv
// Shared defaults and width helper for the class-2 vote accumulator.
package class2_vote_pkg;

    localparam int unsigned NUM_TREES_DEF = 8;
    localparam int unsigned THRESH_DEF    = 5;
    localparam int unsigned CNT_W_DEF     = 16;

    // Bits needed to hold a vote count in 0..n.
    function automatic int unsigned count_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/vote_popcount.sv
// Combinational population count of the per-tree vote bits.
module vote_popcount
    import class2_vote_pkg::*;
#(
    parameter  int unsigned NUM_TREES = NUM_TREES_DEF,
    localparam int unsigned CW        = count_w(NUM_TREES)
) (
    input  logic [NUM_TREES-1:0] votes,
    output logic [CW-1:0]        count_c
);

    always_comb begin
        count_c = '0;
        for (int k = 0; k < int'(NUM_TREES); k++) begin
            count_c = count_c + CW'(votes[k]);
        end
    end

endmodule

// File: rtl/class2_vote_accum.sv
// Two-stage vote accumulator: S1 holds the vote word, S2 the count/decision,
// with saturating statistics of delivered decisions.
module class2_vote_accum
    import class2_vote_pkg::*;
#(
    parameter  int unsigned NUM_TREES = NUM_TREES_DEF,
    parameter  int unsigned THRESH    = THRESH_DEF,
    parameter  int unsigned CNT_W     = CNT_W_DEF,
    localparam int unsigned CW        = count_w(NUM_TREES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NUM_TREES-1:0] in_votes,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_class,
    output logic [CW-1:0]        out_count,
    output logic [CNT_W-1:0]     pos_total,
    output logic [CNT_W-1:0]     sample_total
);

    logic                 s1_valid;
    logic [NUM_TREES-1:0] s1_votes;
    logic [CW-1:0]        s1_count_c;
    logic                 s2_adv_c;
    logic                 s1_adv_c;
    logic                 deliver_c;

    vote_popcount #(.NUM_TREES(NUM_TREES)) u_popcount (
        .votes   (s1_votes),
        .count_c (s1_count_c)
    );

    // S2 can take a new word when empty or delivering; S1 frees up when it moves on.
    assign s2_adv_c  = !out_valid || out_ready;
    assign s1_adv_c  = s1_valid && s2_adv_c;
    assign in_ready  = !s1_valid || s1_adv_c;
    assign deliver_c = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_votes <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_votes <= in_votes;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_count <= '0;
            out_class <= 1'b0;
        end else if (s2_adv_c) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_count <= s1_count_c;
                out_class <= (32'(s1_count_c) >= THRESH);
            end
        end
    end

    // clr wins over a coinciding delivery; that decision goes uncounted.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sample_total <= '0;
            pos_total    <= '0;
        end else if (deliver_c) begin
            if (sample_total != {CNT_W{1'b1}}) begin
                sample_total <= sample_total + CNT_W'(1);
            end
            if (out_class && (pos_total != {CNT_W{1'b1}})) begin
                pos_total <= pos_total + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/class2_vote_accum.md
CLASS2_VOTE_ACCUM -- requirements
Module: class2_vote_accum

Interface
REQ-001 SHALL have parameter NUM_TREES, default 8: number of class-2 tree output bits per sample.
REQ-002 SHALL have parameter THRESH, default 5: minimum vote count for out_class=1.
REQ-003 SHALL have parameter CNT_W, default 16: width of the running statistics counters.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port clr  input  1  synchronous clear of the statistics counters only.
REQ-007 SHALL have port in_valid  input  1  a vote word is present.
REQ-008 SHALL have port in_ready  output  1  block accepts a vote word this cycle.
REQ-009 SHALL have port in_votes  input  NUM_TREES  one bit per tree, bit k = tree k output o.
REQ-010 SHALL have port out_valid  output  1  decision present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts decision.
REQ-012 SHALL have port out_class  output  1  1 when vote count >= THRESH.
REQ-013 SHALL have port out_count  output  clog2(NUM_TREES+1)  number of set bits in the accepted word.
REQ-014 SHALL have port pos_total  output  CNT_W  saturating count of delivered decisions with out_class=1.
REQ-015 SHALL have port sample_total  output  CNT_W  saturating count of delivered decisions.

Function
REQ-016 SHALL accept a word when in_valid && in_ready (input handshake) and deliver when out_valid && out_ready (output handshake).
REQ-017 SHALL be a two-stage pipeline: S1 registers in_votes; S2 registers out_count and out_class computed from S1.
REQ-018 SHALL present a word's decision on out_valid exactly 2 cycles after its input handshake when out_ready is held high.
REQ-019 SHALL sustain one accepted word per cycle with out_ready held high.
REQ-020 SHALL stall when out_valid && !out_ready: S2 holds; S1 advances into S2 only if S2 empty or delivering.
REQ-021 SHALL drive in_ready = !S1_valid || S1 advancing this cycle; no combinational path from in_valid to out_valid or from out_ready to out_class/out_count.
REQ-022 SHALL hold out_class, out_count stable while out_valid && !out_ready.
REQ-023 SHALL never drop, duplicate or reorder words; up to 2 words in flight.
REQ-024 SHALL compute out_class as out_count >= THRESH; THRESH=0 gives always 1, THRESH > NUM_TREES always 0.
REQ-025 SHALL increment sample_total, and pos_total if out_class=1, on each output handshake; each saturates at 2^CNT_W-1.
REQ-026 SHALL, when clr and an output handshake coincide, give clr priority: both counters become 0 and that decision is not counted.
REQ-027 SHALL leave the pipeline contents and handshakes unaffected by clr.

Reset
REQ-028 SHALL on rst clear S1_valid and S2 valid; out_valid=0, out_class=0, out_count=0, pos_total=0, sample_total=0.
REQ-029 SHALL drive in_ready=1 in the first cycle after rst deasserts.
REQ-030 SHALL discard in-flight words when rst asserts mid-operation; rst dominates clr and handshakes.

Structure
REQ-031 SHALL place NUM_TREES default, THRESH default, CNT_W default and the count-width function in shared package class2_vote_pkg.
REQ-032 SHALL instantiate one sub-module, vote_popcount: combinational NUM_TREES-bit population count.

Verification
REQ-033 Bench SHALL cover reset: rst 2 cycles -> out_valid=0, counters 0, in_ready=1 after release.
REQ-034 Bench SHALL cover streaming: words 0xFF, 0x1F, 0x0F, 0x00 back-to-back, out_ready=1 -> out_count 8,5,4,0; out_class 1,1,0,0 at cycles 2-5; pos_total=2, sample_total=4.
REQ-035 Bench SHALL cover backpressure: out_ready=0 for 5 cycles with 3 words offered -> 2 accepted, in_ready=0, out_class/out_count held; on release all 3 delivered in order.
REQ-036 Bench SHALL cover saturation: CNT_W=4, 20 words 0xFF -> sample_total and pos_total stop at 15.
REQ-037 Bench SHALL cover clr: clr coinciding with delivery of 0xFF -> counters 0 next cycle, subsequent 0x3F counted as sample_total=1, pos_total=1.
REQ-038 Bench SHALL cover mid-stream reset: rst with 2 words in flight -> neither word delivered, counters 0.
